// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap or saturate boundaries, synchronous load,
// combinational terminal-count decodes, a one-cycle boundary pulse and a sticky boundary flag.
module updown_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap_pulse,
  output logic             ovf_flag
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_next;
  logic             boundary;

  assign at_max  = (count == MAX);
  assign at_zero = (count == '0);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    count_next = count;
    boundary   = 1'b0;
    if (load) begin
      count_next = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        boundary   = at_max;
        count_next = at_max ? (SATURATE ? MAX : '0) : count + WIDTH'(1);
      end else begin
        boundary   = at_zero;
        count_next = at_zero ? (SATURATE ? '0 : MAX) : count - WIDTH'(1);
      end
    end
  end

  // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      count      <= count_next;
      wrap_pulse <= boundary;
      // A boundary event on the same edge as clr_flag keeps the flag set.
      if (boundary) begin
        ovf_flag <= 1'b1;
      end else if (clr_flag) begin
        ovf_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: three counter configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model plus directed expectations.
module tb_updown_counter_param;

  typedef struct {
    int unsigned cnt;
    bit          wrap;
    bit          ovf;
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load, clr;
  logic [7:0] lv;

  // a: WIDTH=4 MAX=9 wrap; b: WIDTH=8 MAX=255 saturate; c: WIDTH=8 MAX=9 saturate
  logic [3:0] a_count;
  logic [7:0] b_count, c_count;
  logic a_max, a_zero, a_wrap, a_ovf;
  logic b_max, b_zero, b_wrap, b_ovf;
  logic c_max, c_zero, c_wrap, c_ovf;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
    .clr_flag(clr), .count(a_count), .at_max(a_max), .at_zero(a_zero),
    .wrap_pulse(a_wrap), .ovf_flag(a_ovf));

  updown_counter_param #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .clr_flag(clr), .count(b_count), .at_max(b_max), .at_zero(b_zero),
    .wrap_pulse(b_wrap), .ovf_flag(b_ovf));

  updown_counter_param #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .clr_flag(clr), .count(c_count), .at_max(c_max), .at_zero(c_zero),
    .wrap_pulse(c_wrap), .ovf_flag(c_ovf));

  int checks = 0;
  int passed = 0;
  mstate_t ma, mb, mc;

  // Reference: wrap mode is modulo (max+1) arithmetic, saturate mode clamps to [0, max].
  function automatic mstate_t model(mstate_t s, int unsigned maxv, bit sat, bit r, bit l,
                                    int unsigned v, bit e, bit u, bit c);
    mstate_t n;
    bit hit;
    n   = s;
    hit = 1'b0;
    if (r) begin
      n.cnt = 0; n.wrap = 1'b0; n.ovf = 1'b0;
      return n;
    end
    if (l) begin
      n.cnt = (v > maxv) ? maxv : v;
    end else if (e) begin
      hit = u ? (s.cnt == maxv) : (s.cnt == 0);
      if (sat) n.cnt = hit ? s.cnt : (u ? s.cnt + 1 : s.cnt - 1);
      else     n.cnt = u ? (s.cnt + 1) % (maxv + 1) : (s.cnt + maxv) % (maxv + 1);
    end
    n.wrap = hit;
    if (hit) n.ovf = 1'b1;
    else if (c) n.ovf = 1'b0;
    return n;
  endfunction

  function automatic logic [11:0] obs(int k);
    case (k)
      0:       return {4'b0, a_count, a_max, a_zero, a_wrap, a_ovf};
      1:       return {b_count, b_max, b_zero, b_wrap, b_ovf};
      default: return {c_count, c_max, c_zero, c_wrap, c_ovf};
    endcase
  endfunction

  function automatic logic [11:0] expv(int k);
    mstate_t s;
    int unsigned m;
    case (k)
      0:       begin s = ma; m = 9;   end
      1:       begin s = mb; m = 255; end
      default: begin s = mc; m = 9;   end
    endcase
    return {8'(s.cnt), s.cnt == m, s.cnt == 0, s.wrap, s.ovf};
  endfunction

  // One clock: drive inputs, advance the models on the edge, settle past it.
  task automatic step(input bit r, input bit l, input logic [7:0] v, input bit e,
                      input bit u, input bit c);
    rst = r; load = l; lv = v; en = e; up = u; clr = c;
    @(posedge clk);
    ma = model(ma, 9,   1'b0, r, l, v[3:0], e, u, c);
    mb = model(mb, 255, 1'b1, r, l, v,      e, u, c);
    mc = model(mc, 9,   1'b1, r, l, v,      e, u, c);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== expv(k)) $display("FAIL reset dut%0d: got %h expected %h", k, obs(k), expv(k));
      else passed++;
    end
    checks++;
    if ({a_count, a_max, a_zero, a_wrap, a_ovf} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_const: got cnt=%0d max=%b zero=%b wrap=%b ovf=%b expected 0 0 1 0 0",
               a_count, a_max, a_zero, a_wrap, a_ovf);
    else passed++;
  endtask

  task automatic test_up_wrap();
    int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== expv(k)) $display("FAIL up_wrap dut%0d cyc%0d: got %h expected %h", k, i, obs(k), expv(k));
        else passed++;
      end
      checks++;
      if (a_count !== 4'(seq[i]) || a_wrap !== (i == 9) || a_max !== (seq[i] == 9) || a_ovf !== (i >= 9))
        $display("FAIL up_wrap_seq cyc%0d: got cnt=%0d wrap=%b max=%b ovf=%b expected cnt=%0d",
                 i, a_count, a_wrap, a_max, a_ovf, seq[i]);
      else passed++;
    end
  endtask

  task automatic test_down_wrap();
    int seq [4] = '{1, 0, 9, 8};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
      else        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== expv(k)) $display("FAIL down_wrap dut%0d cyc%0d: got %h expected %h", k, i, obs(k), expv(k));
        else passed++;
      end
      checks++;
      if (a_count !== 4'(seq[i]) || a_wrap !== (i == 2))
        $display("FAIL down_wrap_seq cyc%0d: got cnt=%0d wrap=%b expected cnt=%0d wrap=%b",
                 i, a_count, a_wrap, seq[i], i == 2);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b1, 8'd254, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== expv(k)) $display("FAIL sat_up dut%0d cyc%0d: got %h expected %h", k, i, obs(k), expv(k));
        else passed++;
      end
      checks++;
      if (b_count !== 8'd255 || b_wrap !== (i >= 1) || b_max !== 1'b1)
        $display("FAIL sat_up_seq cyc%0d: got cnt=%0d wrap=%b expected cnt=255 wrap=%b", i, b_count, b_wrap, i >= 1);
      else passed++;
    end
    step(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== expv(k)) $display("FAIL sat_down dut%0d cyc%0d: got %h expected %h", k, i, obs(k), expv(k));
        else passed++;
      end
      checks++;
      if (b_count !== 8'd0 || b_zero !== 1'b1 || b_wrap !== (i == 1))
        $display("FAIL sat_down_seq cyc%0d: got cnt=%0d zero=%b wrap=%b expected 0 1 %b", i, b_count, b_zero, b_wrap, i == 1);
      else passed++;
    end
  endtask

  task automatic test_priority();
    step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
    checks++;
    if (a_count !== 4'd5 || b_count !== 8'd5 || c_count !== 8'd5)
      $display("FAIL prio_load_en: got %0d/%0d/%0d expected 5/5/5", a_count, b_count, c_count);
    else passed++;
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
    checks++;
    if (a_count !== 4'd0 || a_ovf !== 1'b0 || b_ovf !== 1'b0 || c_count !== 8'd0)
      $display("FAIL prio_rst_load: got cnt=%0d ovf=%b expected cnt=0 ovf=0", a_count, a_ovf);
    else passed++;
    step(1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
    checks++;
    if (c_count !== 8'd9 || c_max !== 1'b1 || b_count !== 8'd200 || a_count !== 4'd8)
      $display("FAIL prio_clamp: got c=%0d b=%0d a=%0d expected c=9 b=200 a=8", c_count, b_count, a_count);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== expv(k)) $display("FAIL prio dut%0d: got %h expected %h", k, obs(k), expv(k));
      else passed++;
    end
  endtask

  task automatic test_flags();
    step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (a_ovf !== 1'b1 || a_wrap !== 1'b1 || a_count !== 4'd0)
      $display("FAIL flag_set: got ovf=%b wrap=%b cnt=%0d expected 1 1 0", a_ovf, a_wrap, a_count);
    else passed++;
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (a_ovf !== 1'b0 || a_wrap !== 1'b0 || a_count !== 4'd0)
      $display("FAIL flag_clr: got ovf=%b wrap=%b cnt=%0d expected 0 0 0", a_ovf, a_wrap, a_count);
    else passed++;
    step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (a_ovf !== 1'b1 || a_wrap !== 1'b1)
      $display("FAIL flag_clr_vs_wrap: got ovf=%b wrap=%b expected 1 1", a_ovf, a_wrap);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== expv(k)) $display("FAIL flags dut%0d: got %h expected %h", k, obs(k), expv(k));
      else passed++;
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, i[0], 1'b0);
      checks++;
      if (a_count !== 4'd7 || a_wrap !== 1'b0 || c_count !== 8'd7 || b_count !== 8'd7)
        $display("FAIL hold cyc%0d: got a=%0d wrap=%b c=%0d b=%0d expected 7 0 7 7", i, a_count, a_wrap, c_count, b_count);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit r, l, c;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 7) == 0);
      c = !l && ($urandom_range(0, 9) == 0);
      step(r, l, 8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), c);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== expv(k)) $display("FAIL random dut%0d cyc%0d: got %h expected %h", k, i, obs(k), expv(k));
        else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; clr = 1'b0; lv = '0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_flags();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
